grostl_round_seq: RTL and testbench
===================================

// Module: grostl_round_seq
// PURPOSE
//  Iterative Grostl P/Q round sequencer, generalised to 512-bit (COLS=8) and 1024-bit (COLS=16) states.
//  - Accepts one state per job on a valid/ready handshake.
//  - Each cycle it applies AddRoundConstant (P or Q, per-job select) to the held state.
//  - The result goes out to an external rest-of-round datapath (SubBytes/ShiftBytes/MixBytes).
//  - The returned state is registered, and the sequencer steps the round counter.
//  - Sits between the compression-function controller and the round datapath.
// PARAMETERS
//  COLS     8   state columns; legal values 8 (512-bit) or 16 (1024-bit)
//  NROUNDS  10  rounds per permutation; 10 for COLS=8, 14 for COLS=16; legal range 1..16
// PORTS
//  clk        in   1           single clock, all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           job offered
//  in_ready   out  1           job accepted when in_valid && in_ready
//  in_pq      in   1           0 = P permutation, 1 = Q permutation
//  in_state   in   COLS*64     input state, [0:COLS-1][0:7][7:0] = [column][row][byte]
//  rf_o       out  COLS*64     AddRoundConstant(state_q, rnd_q, pq_q) to external round logic
//  rf_i       in   COLS*64     external round result, combinational function of rf_o
//  rnd        out  4           current round index, for observability
//  out_valid  out  1           permutation result available
//  out_ready  in   1           consumer accepts result
//  out_state  out  COLS*64     permutation result
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at a rising edge):
//    - fsm=IDLE, state_q=0, pq_q=0, rnd_q=0.
//    - Outputs: in_ready=1, out_valid=0, out_state=0, rnd=0.
//    - rst overrides every other input, including mid-RUN and during DONE; any in-flight job is discarded.
//  - AddRoundConstant, column j, row i, round r (all XOR):
//    - P: row 0 gets ^= (j<<4)^r; rows 1..7 unchanged.
//    - Q: rows 0..6 get ^= 8'hFF; row 7 gets ^= 8'hFF^(j<<4)^r.
//    - j<<4 truncates to 8 bits; r is zero-extended to 8 bits.
//  - FSM states IDLE, RUN, DONE:
//    - IDLE: in_ready=1. On in_valid: state_q<=in_state, pq_q<=in_pq, rnd_q<=0, go to RUN.
//    - RUN: in_ready=0, out_valid=0. Each cycle state_q<=rf_i.
//      - rnd_q < NROUNDS-1: rnd_q<=rnd_q+1.
//      - rnd_q == NROUNDS-1: go to DONE, and rnd_q<=0.
//    - DONE: out_valid=1, out_state=state_q, held stable until out_ready.
//      - out_ready && !in_valid: go to IDLE.
//      - in_ready = out_ready (back-to-back).
//      - out_ready && in_valid: capture the new job (as in IDLE) and go to RUN in the same cycle.
//  - Latency and throughput:
//    - Acceptance edge at cycle t; out_valid rises at cycle t+NROUNDS.
//    - Throughput: one job per NROUNDS+1 cycles when back-to-back.
//  - rf_o is driven in every state; it is meaningful only in RUN.
//  - out_state is stable whenever out_valid=1.
//  - in_state/in_pq are ignored unless accepted.
//  - out_ready while out_valid=0 has no effect.
//  - Elaboration error if COLS is not 8 or 16, or if NROUNDS is outside 1..16.
// STRUCTURE
//  - grostl_pkg:
//    - typedef state_t = logic [0:COLS-1][0:7][7:0] (parametrised via macro/function).
//    - fsm enum {IDLE,RUN,DONE}.
//    - constants AC_Q_FILL=8'hFF, AC_COL_SHIFT=4, NROUNDS_512=10, NROUNDS_1024=14.
//  - Sub-module grostl_add_constant_gen #(COLS): combinational P/Q AddRoundConstant.
//    - Ports: din, pq, rnd[3:0], dout.
//    - Instantiated once; pq selects P or Q inside it.
//  - This module holds the FSM, round counter, state/pq registers and handshake logic only.
// TESTING (bench loops rf_i = rf_o unless stated)
//  - Reset: hold rst 2 cycles, then check in_ready=1, out_valid=0, out_state=0, rnd=0.
//  - COLS=8, NROUNDS=10, P, in_state=0:
//    - out_valid exactly 10 cycles after accept.
//    - Every column: row0 = 8'h01, all other bytes 8'h00.
//  - COLS=8, Q, in_state=0: every column row7 = 8'h01, rows 0..6 = 8'h00.
//  - COLS=16, NROUNDS=14, P, in_state=0: all 16 columns row0 = 8'h01, others 8'h00, latency 14 cycles.
//  - Back-to-back and backpressure:
//    - Hold out_ready=0 for 5 cycles in DONE: out_state stable, in_ready=0.
//    - Then out_ready=1 with in_valid=1: new job is accepted in the same cycle, and the next out_valid comes 10 cycles later.
//  - Reset mid-RUN: assert rst at round 4; next cycle shows IDLE and out_valid never asserts for that job.
//  - rf_i = rf_o ^ const: 8'hA5 in every byte for P, state 0.
//    - Check rnd sequence 0..9.
//    - Check result against a reference model.

Source files
------------

// File: rtl/grostl_pkg.sv
// Shared types and constants for the iterative Grostl P/Q round sequencer.
// GROSTL_STATE_T(cols) gives the [column][row][byte] view of a state; column 0 sits in the MSBs.
`define GROSTL_STATE_T(cols) logic [0:(cols)-1][0:7][7:0]

package grostl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] AC_Q_FILL    = 8'hFF;
    localparam int         AC_COL_SHIFT = 4;
    localparam int         NROUNDS_512  = 10;
    localparam int         NROUNDS_1024 = 14;

    function automatic int state_bits(input int cols);
        return cols * 64;
    endfunction

    // Column/round term of the round constant: (j<<4) truncated to a byte, then XOR r.
    function automatic logic [7:0] ac_col(input int col, input logic [3:0] rnd);
        logic [7:0] sh;
        sh = 8'(col << AC_COL_SHIFT);
        return sh ^ {4'h0, rnd};
    endfunction

endpackage

// File: rtl/grostl_add_constant_gen.sv
// Combinational Grostl AddRoundConstant for either permutation.
// pq = 0 selects P, pq = 1 selects Q.
module grostl_add_constant_gen
    import grostl_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic [COLS*64-1:0] din,
    input  logic               pq,
    input  logic [3:0]         rnd,
    output logic [COLS*64-1:0] dout
);

    typedef `GROSTL_STATE_T(COLS) state_t;

    state_t s_in;
    state_t s_out;

    assign s_in = din;
    assign dout = s_out;

    always_comb begin
        s_out = s_in;
        for (int j = 0; j < COLS; j++) begin
            if (pq) begin
                for (int i = 0; i < 7; i++) begin
                    s_out[j][i] = s_in[j][i] ^ AC_Q_FILL;
                end
                s_out[j][7] = s_in[j][7] ^ AC_Q_FILL ^ ac_col(j, rnd);
            end else begin
                s_out[j][0] = s_in[j][0] ^ ac_col(j, rnd);
            end
        end
    end

endmodule

// File: rtl/grostl_round_seq.sv
// Iterative Grostl P/Q round sequencer: holds one state, applies the round constant,
// hands it to the external round datapath and registers the result each round.
//
// state | meaning
// IDLE  | no job held, in_ready=1
// RUN   | rounds in progress, state_q <= rf_i every cycle
// DONE  | result on out_state, waits for out_ready; may accept the next job in the same cycle
module grostl_round_seq
    import grostl_pkg::*;
#(
    parameter int COLS    = 8,
    parameter int NROUNDS = NROUNDS_512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_pq,
    input  logic [COLS*64-1:0] in_state,
    output logic [COLS*64-1:0] rf_o,
    input  logic [COLS*64-1:0] rf_i,
    output logic [3:0]         rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLS*64-1:0] out_state
);

    localparam int         W        = state_bits(COLS);
    localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);

    if (COLS != 8 && COLS != 16) begin : g_bad_cols
        $error("grostl_round_seq: COLS must be 8 or 16");
    end
    if (NROUNDS < 1 || NROUNDS > 16) begin : g_bad_nrounds
        $error("grostl_round_seq: NROUNDS must be within 1..16");
    end

    fsm_t         fsm_q;
    fsm_t         fsm_nx;
    logic [W-1:0] state_q;
    logic         pq_q;
    logic [3:0]   rnd_q;
    logic         accept;
    logic         last_rnd;

    assign accept   = in_valid && in_ready;
    assign last_rnd = (rnd_q == LAST_RND);
    assign rnd      = rnd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_nx;
        end
    end

    always_comb begin
        fsm_nx = fsm_q;
        case (fsm_q)
            IDLE: if (in_valid) fsm_nx = RUN;
            RUN:  if (last_rnd) fsm_nx = DONE;
            DONE: if (out_ready) fsm_nx = in_valid ? RUN : IDLE;
            default: fsm_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_state = '0;
        case (fsm_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                out_state = state_q;
            end
            default: ;
        endcase
    end

    // A DONE-state accept reloads here directly, so the next job starts without an idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            pq_q    <= 1'b0;
            rnd_q   <= '0;
        end else if (accept) begin
            state_q <= in_state;
            pq_q    <= in_pq;
            rnd_q   <= '0;
        end else if (fsm_q == RUN) begin
            state_q <= rf_i;
            rnd_q   <= last_rnd ? 4'd0 : rnd_q + 4'd1;
        end
    end

    grostl_add_constant_gen #(
        .COLS(COLS)
    ) u_add_constant (
        .din  (state_q),
        .pq   (pq_q),
        .rnd  (rnd_q),
        .dout (rf_o)
    );

endmodule

// File: tb/tb_grostl_round_seq.sv
// Bench for grostl_round_seq: a 512-bit/10-round and a 1024-bit/14-round instance, each with
// rf_i looped back from rf_o (optionally XORed with a per-byte mask), checked against a job-level model.
module tb_grostl_round_seq;

    localparam logic [1023:0] P8_LIT  = {512'b0, {8{64'h0100_0000_0000_0000}}};
    localparam logic [1023:0] Q8_LIT  = {512'b0, {8{64'h0000_0000_0000_0001}}};
    localparam logic [1023:0] P16_LIT = {16{64'h0100_0000_0000_0000}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic [1:0]          in_valid;
    logic [1:0]          in_pq;
    logic [1:0]          out_ready;
    logic [1:0][1023:0]  in_state;
    logic [1:0][7:0]     mask;
    logic [1:0]          in_ready;
    logic [1:0]          out_valid;
    logic [1:0][3:0]     rnd;
    logic [1:0][1023:0]  osx;
    logic [511:0]        rf_o8, rf_i8, out_state8;
    logic [1023:0]       rf_o16, rf_i16, out_state16;

    assign rf_i8  = rf_o8 ^ {64{mask[0]}};
    assign rf_i16 = rf_o16 ^ {128{mask[1]}};
    assign osx[0] = {512'b0, out_state8};
    assign osx[1] = out_state16;

    grostl_round_seq #(.COLS(8), .NROUNDS(10)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pq(in_pq[0]),
        .in_state(in_state[0][511:0]),
        .rf_o(rf_o8), .rf_i(rf_i8), .rnd(rnd[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state8)
    );

    grostl_round_seq #(.COLS(16), .NROUNDS(14)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pq(in_pq[1]),
        .in_state(in_state[1]),
        .rf_o(rf_o16), .rf_i(rf_i16), .rnd(rnd[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state16)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic int nr_of(input int k);
        return (k == 0) ? 10 : 14;
    endfunction

    function automatic int cols_of(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    // Whole permutation straight from the round rules: per round add the constant, then XOR the loop mask.
    function automatic logic [1023:0] perm(input logic [1023:0] s, input int cols, input int nr,
                                           input bit pq, input logic [7:0] m);
        logic [7:0]    b [16][8];
        logic [1023:0] o;
        int            c;
        for (int j = 0; j < cols; j++)
            for (int i = 0; i < 8; i++)
                b[j][i] = s[cols*64-1-8*(j*8+i) -: 8];
        for (int r = 0; r < nr; r++) begin
            for (int j = 0; j < cols; j++) begin
                c = ((j * 16) ^ r) & 255;
                for (int i = 0; i < 8; i++) begin
                    if (pq) b[j][i] = b[j][i] ^ 8'hFF ^ ((i == 7) ? 8'(c) : 8'h00);
                    else if (i == 0) b[j][i] = b[j][i] ^ 8'(c);
                    b[j][i] = b[j][i] ^ m;
                end
            end
        end
        o = '0;
        for (int j = 0; j < cols; j++)
            for (int i = 0; i < 8; i++)
                o[cols*64-1-8*(j*8+i) -: 8] = b[j][i];
        return o;
    endfunction

    task automatic check_v(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d act=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic check_s(input string nm, input int k, input logic [1023:0] act, input logic [1023:0] exp);
        int  idx;
        bit  found;
        checks++;
        if (act !== exp) begin
            errors++;
            found = 1'b0;
            idx   = 0;
            for (int b = 127; b >= 0; b--)
                if (!found && act[8*b +: 8] !== exp[8*b +: 8]) begin
                    found = 1'b1;
                    idx   = b;
                end
            $display("FAIL %s inst%0d byte_lsb%0d act=%h exp=%h t=%0t",
                     nm, k, idx, act[8*idx +: 8], exp[8*idx +: 8], $time);
        end
    endtask

    // Job-level model: a running job completes nr cycles after acceptance and its result is held until taken.
    bit            m_run  [2];
    bit            m_done [2];
    int            m_left [2];
    logic [1023:0] m_pend [2];
    logic [1023:0] m_res  [2];
    bit            m_rdy;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k]  = 1'b0;
                m_done[k] = 1'b0;
                m_left[k] = 0;
                m_res[k]  = '0;
            end else begin
                m_rdy = !m_run[k] && (!m_done[k] || out_ready[k]);
                if (m_done[k] && out_ready[k]) m_done[k] = 1'b0;
                if (m_run[k]) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_run[k]  = 1'b0;
                        m_done[k] = 1'b1;
                        m_res[k]  = m_pend[k];
                    end
                end
                if (in_valid[k] && m_rdy) begin
                    m_run[k]  = 1'b1;
                    m_left[k] = nr_of(k);
                    m_pend[k] = perm(in_state[k], cols_of(k), nr_of(k), in_pq[k], mask[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check_v("in_ready", k, 32'(in_ready[k]),
                        32'(!m_run[k] && (!m_done[k] || out_ready[k])));
                check_v("out_valid", k, 32'(out_valid[k]), 32'(m_done[k]));
                check_v("rnd", k, 32'(rnd[k]), m_run[k] ? 32'(nr_of(k) - m_left[k]) : 32'd0);
                check_s("out_state", k, osx[k], m_done[k] ? m_res[k] : 1024'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k, input logic [1023:0] st, input bit pq);
        in_valid[k] = 1'b1;
        in_state[k] = st;
        in_pq[k]    = pq;
        tick();
        in_valid[k] = 1'b0;
        in_state[k] = '1;
        in_pq[k]    = ~pq;
    endtask

    // Counts edges from the acceptance edge until out_valid is seen; also pins the rnd sequence.
    task automatic wait_done(input int k, input int lat, input string nm);
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (!out_valid[k] && cnt < lat) check_v({nm, "_rnd_seq"}, k, 32'(rnd[k]), 32'(cnt));
        end while (!out_valid[k] && cnt < 40);
        check_v({nm, "_latency"}, k, 32'(cnt), 32'(lat));
    endtask

    task automatic release_out(input int k);
        tick();
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    logic [1023:0] held;
    int            cnt;

    initial begin
        in_valid  = '0;
        in_pq     = '0;
        out_ready = '0;
        in_state  = '0;
        mask      = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_v("reset_in_ready", k, 32'(in_ready[k]), 32'd1);
            check_v("reset_out_valid", k, 32'(out_valid[k]), 32'd0);
            check_v("reset_rnd", k, 32'(rnd[k]), 32'd0);
            check_s("reset_out_state", k, osx[k], 1024'b0);
        end
        chk_en = 1'b1;

        check_s("model_p8", 0, perm('0, 8, 10, 1'b0, 8'h00), P8_LIT);
        check_s("model_q8", 0, perm('0, 8, 10, 1'b1, 8'h00), Q8_LIT);
        check_s("model_p16", 1, perm('0, 16, 14, 1'b0, 8'h00), P16_LIT);
        check_s("model_p8_mask", 0, perm('0, 8, 10, 1'b0, 8'hA5), P8_LIT);

        tick();
        start_job(0, '0, 1'b0);
        wait_done(0, 10, "p8");
        check_s("p8_result", 0, osx[0], P8_LIT);
        release_out(0);

        tick();
        start_job(0, '0, 1'b1);
        wait_done(0, 10, "q8");
        check_s("q8_result", 0, osx[0], Q8_LIT);
        release_out(0);

        tick();
        start_job(1, '0, 1'b0);
        wait_done(1, 14, "p16");
        check_s("p16_result", 1, osx[1], P16_LIT);
        release_out(1);

        tick();
        start_job(0, {512'b0, {16{32'h1357_9BDF}}}, 1'b0);
        wait_done(0, 10, "bp_first");
        held = osx[0];
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            check_s("bp_hold_state", 0, osx[0], held);
            check_v("bp_hold_in_ready", 0, 32'(in_ready[0]), 32'd0);
            check_v("bp_hold_valid", 0, 32'(out_valid[0]), 32'd1);
        end
        tick();
        out_ready[0] = 1'b1;
        start_job(0, {512'b0, {8{64'hDEAD_BEEF_0F1E_2D3C}}}, 1'b1);
        out_ready[0] = 1'b0;
        wait_done(0, 10, "b2b_second");
        release_out(0);

        tick();
        start_job(0, '0, 1'b0);
        cnt = 0;
        while (rnd[0] != 4'd4 && cnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check_v("midrun_reach_rnd4", 0, 32'(rnd[0]), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_v("midrun_rst_in_ready", 0, 32'(in_ready[0]), 32'd1);
        check_v("midrun_rst_rnd", 0, 32'(rnd[0]), 32'd0);
        for (int c = 0; c < 15; c++) begin
            check_v("midrun_no_valid", 0, 32'(out_valid[0]), 32'd0);
            tick();
            @(negedge clk);
        end

        mask[0] = 8'hA5;
        tick();
        start_job(0, '0, 1'b0);
        wait_done(0, 10, "mask_a5");
        check_s("mask_a5_result", 0, osx[0], P8_LIT);
        release_out(0);
        mask[0] = 8'h00;

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
